// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared frame geometry and controller state encoding
package ov7670_pkg;
  localparam int H_PIX = 176;
  localparam int V_LIN = 144;
  localparam int FRAME_PIX = H_PIX * V_LIN;
  localparam int AW = 16;
  typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, CHECK} state_t;
endpackage

// File: rtl/ov7670_frame_ctrl_if.sv
// ov7670_frame_ctrl_if: ping-pong frame buffer write port
interface ov7670_frame_ctrl_if;
  import ov7670_pkg::*;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  modport master(output mem_we, mem_addr);
  modport slave(input mem_we, mem_addr);
endinterface

// File: rtl/ov7670_edge_det.sv
// ov7670_edge_det: registers a camera sync line and flags its rising/falling edges
module ov7670_edge_det (
  input  logic Pclock,
  input  logic Reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  // one-cycle history of the sync line
  always_ff @(posedge Pclock) q <= Reset ? 1'b0 : d;
  assign rise = d & ~q;
  assign fall = ~d & q;
endmodule

// File: rtl/ov7670_frame_ctrl.sv
// ov7670_frame_ctrl: arms on request, captures one whole frame into the write bank, commits on exact pixel count
module ov7670_frame_ctrl
  import ov7670_pkg::*;
(
  input  logic                Pclock,
  input  logic                Reset,
  input  logic                Vsync,
  input  logic                WPixel_in,
  input  logic [14:0]         PAddress_in,
  input  logic                start,
  input  logic                continuous,
  input  logic                stop,
  ov7670_frame_ctrl_if.master mem,
  output logic                busy,
  output logic                done,
  output logic                frame_err,
  output logic                ready_bank,
  output logic [7:0]          frame_count
);
  state_t state;
  logic bank_wr, over, vs_q, vs_rise, vs_fall, addr_ok;
  logic [14:0] pix_cnt;
  logic [AW-1:0] wr_addr;
  ov7670_edge_det u_vs (
    .Pclock(Pclock),
    .Reset (Reset),
    .d     (Vsync),
    .q     (vs_q),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );
  assign addr_ok = PAddress_in < 15'(FRAME_PIX);
  assign wr_addr = (bank_wr ? AW'(FRAME_PIX) : AW'(0)) + AW'(PAddress_in);
  assign busy = state != IDLE;
  // frame sequencer with registered write port and status
  always_ff @(posedge Pclock) begin
    if (Reset) begin
      state        <= IDLE;
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
      done         <= 1'b0;
      frame_err    <= 1'b0;
      ready_bank   <= 1'b0;
      bank_wr      <= 1'b1;
      frame_count  <= '0;
      pix_cnt      <= '0;
      over         <= 1'b0;
    end else begin
      mem.mem_we <= 1'b0;
      done       <= 1'b0;
      if (stop && state != IDLE) state <= IDLE;
      else case (state)
        IDLE: if (start) begin
          state     <= ARM;
          frame_err <= 1'b0;
        end
        ARM: if (Vsync) state <= SYNC;
        SYNC: if (vs_fall) begin
          state   <= CAPTURE;
          pix_cnt <= '0;
          over    <= 1'b0;
        end
        CAPTURE: begin
          if (WPixel_in && addr_ok) begin
            mem.mem_we   <= 1'b1;
            mem.mem_addr <= wr_addr;
            pix_cnt      <= pix_cnt == 15'(FRAME_PIX + 1) ? pix_cnt : pix_cnt + 15'd1;
          end
          over <= over | (WPixel_in & ~addr_ok);
          if (vs_rise) state <= CHECK;
        end
        CHECK: begin
          if (pix_cnt == 15'(FRAME_PIX) && !over) begin
            ready_bank  <= bank_wr;
            bank_wr     <= ~bank_wr;
            done        <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else frame_err <= 1'b1;
          state <= continuous ? ARM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// tb_ov7670_frame_ctrl: randomized frame stimulus against a frame-level reference model
module tb_ov7670_frame_ctrl;
  import ov7670_pkg::*;
  logic Pclock, Reset, Vsync, WPixel_in, start, continuous, stop;
  logic [14:0] PAddress_in;
  logic busy, done, frame_err, ready_bank;
  logic [7:0] frame_count;
  ov7670_frame_ctrl_if bus ();
  ov7670_frame_ctrl dut (
    .Pclock     (Pclock),
    .Reset      (Reset),
    .Vsync      (Vsync),
    .WPixel_in  (WPixel_in),
    .PAddress_in(PAddress_in),
    .start      (start),
    .continuous (continuous),
    .stop       (stop),
    .mem        (bus.master),
    .busy       (busy),
    .done       (done),
    .frame_err  (frame_err),
    .ready_bank (ready_bank),
    .frame_count(frame_count)
  );
  int checks = 0, errors = 0, done_cnt = 0;
  logic [15:0] obs[$], exq[$];
  bit m_ready, m_err;
  int m_count;
  initial Pclock = 1'b0;
  always #5 Pclock = ~Pclock;
  always @(negedge Pclock) begin
    if (bus.mem_we === 1'b1) obs.push_back(bus.mem_addr);
    if (done === 1'b1) done_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic tick();
    @(posedge Pclock);
    #1;
  endtask
  task automatic cmp_writes(input string tag);
    int mis = 0;
    chk({tag, "_nwr"}, obs.size(), exq.size());
    for (int i = 0; i < obs.size() && i < exq.size(); i++) if (obs[i] !== exq[i]) mis++;
    chk({tag, "_addr"}, mis, 0);
    obs.delete();
    exq.delete();
  endtask
  task automatic chk_status(input string tag, input bit want_busy);
    chk({tag, "_ready"}, ready_bank, m_ready);
    chk({tag, "_count"}, frame_count, m_count % 256);
    chk({tag, "_err"}, frame_err, m_err);
    chk({tag, "_busy"}, busy, want_busy);
  endtask
  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_err = 1'b0;
    @(negedge Pclock);
    chk("start_busy", busy, 1);
    chk("start_err", frame_err, 0);
  endtask
  // abort_kind: 0 none, 1 stop, 2 reset at pixel abort_at
  task automatic frame(input string tag, input int npix, input int oob_at, input int abort_kind, input int abort_at);
    int off = $urandom_range(0, FRAME_PIX - 1);
    int valid = 0, d0 = done_cnt;
    bit oob = 1'b0, good;
    logic [15:0] a;
    Vsync = 1'b1;
    repeat ($urandom_range(3, 8)) tick();
    Vsync = 1'b0;
    tick();
    tick();
    for (int i = 0; i < npix; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        WPixel_in = 1'b0;
        tick();
      end
      a = (i == oob_at) ? 16'($urandom_range(FRAME_PIX, 32767)) : 16'((off + i) % FRAME_PIX);
      WPixel_in = 1'b1;
      PAddress_in = a[14:0];
      if (abort_kind != 0 && i == abort_at) begin
        if (abort_kind == 1) stop = 1'b1;
        else Reset = 1'b1;
        tick();
        stop = 1'b0;
        Reset = 1'b0;
        WPixel_in = 1'b0;
        @(negedge Pclock);
        if (abort_kind == 2) begin
          m_ready = 1'b0;
          m_count = 0;
          m_err = 1'b0;
          chk({tag, "_rst_addr"}, bus.mem_addr, 0);
        end
        chk({tag, "_we"}, bus.mem_we, 0);
        chk({tag, "_done"}, done, 0);
        chk_status(tag, 1'b0);
        cmp_writes(tag);
        Vsync = 1'b1;
        tick();
        tick();
        return;
      end
      if (a < FRAME_PIX) begin
        valid++;
        exq.push_back(16'((m_ready ? 0 : FRAME_PIX) + int'(a)));
      end else oob = 1'b1;
      if (i == npix - 1) Vsync = 1'b1;
      tick();
    end
    WPixel_in = 1'b0;
    repeat (4) tick();
    good = valid == FRAME_PIX && !oob;
    if (good) begin
      m_ready = !m_ready;
      m_count++;
    end else m_err = 1'b1;
    cmp_writes(tag);
    chk({tag, "_done"}, done_cnt - d0, good);
    chk_status(tag, continuous);
  endtask
  initial begin
    int n;
    Reset = 1'b1;
    Vsync = 1'b0;
    WPixel_in = 1'b0;
    PAddress_in = '0;
    start = 1'b0;
    continuous = 1'b0;
    stop = 1'b0;
    m_ready = 1'b0;
    m_err = 1'b0;
    m_count = 0;
    repeat (3) tick();
    Reset = 1'b0;
    @(negedge Pclock);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_done", done, 0);
    chk_status("rst", 1'b0);
    start_pulse();
    repeat (200) begin
      WPixel_in = 1'b1;
      PAddress_in = 15'($urandom_range(0, FRAME_PIX - 1));
      tick();
    end
    WPixel_in = 1'b0;
    tick();
    chk("midframe_nwr", obs.size(), 0);
    obs.delete();
    frame("first", FRAME_PIX, -1, 0, 0);
    start_pulse();
    frame("short", $urandom_range(1, 300), -1, 0, 0);
    start_pulse();
    n = $urandom_range(20, 300);
    frame("oob", n, $urandom_range(0, n - 2), 0, 0);
    continuous = 1'b1;
    start_pulse();
    frame("cont0", FRAME_PIX, -1, 0, 0);
    frame("cont1", FRAME_PIX, -1, 0, 0);
    frame("stop", 600, -1, 1, $urandom_range(0, 500));
    continuous = 1'b0;
    start_pulse();
    frame("reset", 600, -1, 2, $urandom_range(0, 500));
    start_pulse();
    frame("post_rst", $urandom_range(1, 300), -1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
